// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - push-button conditioner signal bundle
interface button_conditioner_if #(
    parameter int NBTN = 5
);
    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] btn_level;
    logic [NBTN-1:0] btn_press;
    logic [NBTN-1:0] btn_release;
    logic [NBTN-1:0] btn_repeat;
    logic            btn_any_press;

    // board side: drives raw pins, consumes conditioned events
    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_repeat,
        input  btn_any_press
    );

    // conditioner side
    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_repeat,
        output btn_any_press
    );
endinterface

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-button synchroniser, debouncer, edge and auto-repeat generator
module button_conditioner #(
    parameter int NBTN          = 5,
    parameter int DEB_CYCLES    = 250000,
    parameter int LONG_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic                 MCLK,
    input  logic                 RESET,
    button_conditioner_if.slave  btn_if
);
    localparam int DEB_W    = $clog2(DEB_CYCLES) + 1;
    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX) + 1;

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_LONG,
        ST_REPEATING
    } rpt_state_t;

    logic [NBTN-1:0] w_level;
    logic [NBTN-1:0] w_press;
    logic [NBTN-1:0] w_release;
    logic [NBTN-1:0] w_repeat;
    logic [NBTN-1:0] w_press_evt;
    logic            r_any_press;

    genvar g;
    generate
        for (g = 0; g < NBTN; g++) begin : g_lane
            logic              r_sync1;
            logic              r_sync2;
            logic              r_stable;
            logic [DEB_W-1:0]  r_deb_cnt;
            logic              r_press;
            logic              r_release;
            logic              r_repeat;
            rpt_state_t        r_state;
            rpt_state_t        w_state_next;
            logic [HOLD_W-1:0] r_hold_cnt;
            logic [HOLD_W-1:0] w_hold_next;
            logic              w_repeat_next;
            logic              w_flip;
            logic              w_stable_next;
            logic              w_lane_press;
            logic              w_lane_release;

            // the level flips only after DEB_CYCLES consecutive disagreeing samples
            assign w_flip         = (r_sync2 != r_stable) && (r_deb_cnt == DEB_LAST);
            assign w_stable_next  = w_flip ? r_sync2 : r_stable;
            assign w_lane_press   = w_flip &  r_sync2;
            assign w_lane_release = w_flip & ~r_sync2;

            // synchroniser, debounce counter, stable level and edge pulses
            always_ff @(posedge MCLK or posedge RESET) begin
                if (RESET) begin
                    r_sync1   <= 1'b0;
                    r_sync2   <= 1'b0;
                    r_stable  <= 1'b0;
                    r_deb_cnt <= '0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                end else begin
                    r_sync1   <= btn_if.btn_raw[g];
                    r_sync2   <= r_sync1;
                    r_press   <= w_lane_press;
                    r_release <= w_lane_release;
                    if (r_sync2 == r_stable) begin
                        r_deb_cnt <= '0;
                    end else if (w_flip) begin
                        r_stable  <= r_sync2;
                        r_deb_cnt <= '0;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + DEB_W'(1);
                    end
                end
            end

            // auto-repeat next state; a falling level wins over any due repeat
            always_comb begin
                w_state_next  = r_state;
                w_hold_next   = r_hold_cnt;
                w_repeat_next = 1'b0;
                if (!w_stable_next) begin
                    w_state_next = ST_IDLE;
                    w_hold_next  = '0;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            if (w_lane_press) begin
                                w_state_next = ST_WAIT_LONG;
                                w_hold_next  = '0;
                            end
                        end
                        ST_WAIT_LONG: begin
                            if (r_hold_cnt == LONG_LAST) begin
                                w_repeat_next = 1'b1;
                                w_hold_next   = '0;
                                w_state_next  = ST_REPEATING;
                            end else begin
                                w_hold_next = r_hold_cnt + HOLD_W'(1);
                            end
                        end
                        ST_REPEATING: begin
                            if (r_hold_cnt == REP_LAST) begin
                                w_repeat_next = 1'b1;
                                w_hold_next   = '0;
                            end else begin
                                w_hold_next = r_hold_cnt + HOLD_W'(1);
                            end
                        end
                        default: begin
                            w_state_next = ST_IDLE;
                            w_hold_next  = '0;
                        end
                    endcase
                end
            end

            // auto-repeat state, hold counter and registered repeat pulse
            always_ff @(posedge MCLK or posedge RESET) begin
                if (RESET) begin
                    r_state    <= ST_IDLE;
                    r_hold_cnt <= '0;
                    r_repeat   <= 1'b0;
                end else begin
                    r_state    <= w_state_next;
                    r_hold_cnt <= w_hold_next;
                    r_repeat   <= w_repeat_next;
                end
            end

            assign w_level[g]     = r_stable;
            assign w_press[g]     = r_press;
            assign w_release[g]   = r_release;
            assign w_repeat[g]    = r_repeat;
            assign w_press_evt[g] = w_lane_press;
        end
    endgenerate

    // any-press is registered from the same events so it lines up with btn_press
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            r_any_press <= 1'b0;
        end else begin
            r_any_press <= |w_press_evt;
        end
    end

    assign btn_if.btn_level     = w_level;
    assign btn_if.btn_press     = w_press;
    assign btn_if.btn_release   = w_release;
    assign btn_if.btn_repeat    = w_repeat;
    assign btn_if.btn_any_press = r_any_press;
endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
module tb_button_conditioner;
    logic MCLK;
    logic RESET;
    int   n_cmp = 0;
    int   n_err = 0;

    button_conditioner_if #(.NBTN(5)) bif ();

    button_conditioner #(
        .NBTN         (5),
        .DEB_CYCLES   (4),
        .LONG_CYCLES  (10),
        .REPEAT_CYCLES(3)
    ) dut (
        .MCLK  (MCLK),
        .RESET (RESET),
        .btn_if(bif)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".level"},   32'(bif.btn_level),     32'h0);
        check({tag, ".press"},   32'(bif.btn_press),     32'h0);
        check({tag, ".release"}, 32'(bif.btn_release),   32'h0);
        check({tag, ".repeat"},  32'(bif.btn_repeat),    32'h0);
        check({tag, ".any"},     32'(bif.btn_any_press), 32'h0);
    endtask

    initial begin
        logic exp_rep;
        RESET       = 1'b1;
        bif.btn_raw = 5'b00000;
        tick();
        tick();
        check_all_zero("reset");
        RESET = 1'b0;
        tick();

        // clean press on lane 4
        bif.btn_raw = 5'b10000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("press4_wait.level", 32'(bif.btn_level), 32'h0);
            check("press4_wait.press", 32'(bif.btn_press), 32'h0);
        end
        tick();
        check("press4.level", 32'(bif.btn_level),     32'h10);
        check("press4.press", 32'(bif.btn_press),     32'h10);
        check("press4.any",   32'(bif.btn_any_press), 32'h1);
        tick();
        check("press4_after.press", 32'(bif.btn_press),     32'h0);
        check("press4_after.any",   32'(bif.btn_any_press), 32'h0);
        check("press4_after.level", 32'(bif.btn_level),     32'h10);
        bif.btn_raw = 5'b00000;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("rel4.release", 32'(bif.btn_release), (i == 6) ? 32'h10 : 32'h0);
            check("rel4.level",   32'(bif.btn_level),   (i == 6) ? 32'h0  : 32'h10);
            check("rel4.repeat",  32'(bif.btn_repeat),  32'h0);
        end
        for (int i = 0; i < 4; i++) tick();
        check_all_zero("quiet1");

        // bounce on lane 0: three 3-cycle highs separated by 3-cycle lows
        for (int c = 0; c < 24; c++) begin
            bif.btn_raw[0] = (c < 3) || (c >= 6 && c < 9) || (c >= 12 && c < 15);
            tick();
            check("bounce", 32'({bif.btn_level, bif.btn_press, bif.btn_release}), 32'h0);
        end

        // auto-repeat on lane 2, then release while a repeat is due
        bif.btn_raw = 5'b00100;
        for (int i = 0; i < 5; i++) tick();
        tick();
        check("press2.press", 32'(bif.btn_press), 32'h4);
        check("press2.any",   32'(bif.btn_any_press), 32'h1);
        for (int t = 1; t <= 42; t++) begin
            tick();
            exp_rep = (t >= 10) && (t < 37) && ((t - 10) % 3 == 0);
            check("rep2.repeat",  32'(bif.btn_repeat),     32'({2'b00, exp_rep, 2'b00}));
            check("rep2.release", 32'(bif.btn_release[2]), 32'(t == 37));
            check("rep2.level",   32'(bif.btn_level[2]),   32'(t < 37));
            check("rep2.press",   32'(bif.btn_press),      32'h0);
            if (t == 31) bif.btn_raw[2] = 1'b0;
        end

        // simultaneous press on lanes 1 and 3
        bif.btn_raw = 5'b01010;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("sim_wait.press", 32'(bif.btn_press), 32'h0);
        end
        tick();
        check("sim.press", 32'(bif.btn_press),     32'h0a);
        check("sim.any",   32'(bif.btn_any_press), 32'h1);
        tick();
        check("sim_after.press", 32'(bif.btn_press),     32'h0);
        check("sim_after.any",   32'(bif.btn_any_press), 32'h0);
        bif.btn_raw = 5'b00000;
        for (int i = 0; i < 10; i++) tick();
        check_all_zero("quiet2");

        // reset while lane 4 is held
        bif.btn_raw = 5'b10000;
        for (int i = 0; i < 6; i++) tick();
        check("hold4.level", 32'(bif.btn_level), 32'h10);
        tick();
        tick();
        RESET = 1'b1;
        #1;
        check_all_zero("async_reset");
        tick();
        tick();
        check_all_zero("in_reset");
        RESET = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("post_reset.press", 32'(bif.btn_press), (i == 6) ? 32'h10 : 32'h0);
            check("post_reset.level", 32'(bif.btn_level), (i == 6) ? 32'h10 : 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
